// File: rtl/serial_skip_adder.sv
// Digit-serial adder/subtractor: D bits per clock through a registered carry-skip
// digit stage, N-bit result with carry-out and signed overflow after N/D cycles.
module serial_skip_adder #(
    parameter int N = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int STEPS = N / D;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_sum_sh;
    logic [N-1:0]  r_sum;
    logic          r_cout;
    logic          r_ovf;

    logic [D-1:0]  w_a_d;
    logic [D-1:0]  w_b_d;
    logic [D-1:0]  w_p;
    logic [D:0]    w_rc;
    logic [D-1:0]  w_dsum;
    logic          w_dcout;
    logic          w_c_msb;
    logic [N-1:0]  w_sum_next;

    assign w_a_d = r_a[D-1:0];
    assign w_b_d = r_b[D-1:0];
    assign w_p   = w_a_d ^ w_b_d;

    // Ripple chain for the digit sum; the carry-out bypasses it when every bit propagates.
    // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
    always_comb begin
        w_rc    = '0;
        w_dsum  = '0;
        w_rc[0] = r_carry;
        for (int i = 0; i < D; i++) begin
            w_dsum[i]  = w_p[i] ^ w_rc[i];
            w_rc[i+1]  = (w_a_d[i] & w_b_d[i]) | (w_p[i] & w_rc[i]);
        end
        w_dcout = (&w_p) ? r_carry : w_rc[D];
        w_c_msb = w_rc[D-1];
    end

    // New digit enters at the top; after STEPS shifts digit 0 sits at the bottom.
    assign w_sum_next = N'({w_dsum, r_sum_sh} >> D);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the shift registers are reset too, so a reset mid-RUN leaves no partial result behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum_sh <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= CW'(STEPS - 1);
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_sum_sh <= w_sum_next;
                    r_a      <= r_a >> D;
                    r_b      <= r_b >> D;
                    r_carry  <= w_dcout;
                    if (r_cnt == '0) begin
                        r_sum   <= w_sum_next;
                        r_cout  <= w_dcout;
                        r_ovf   <= w_c_msb ^ w_dcout;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_skip_adder.sv
// Bench for serial_skip_adder: three instances (D=4, D=1, D=16) checked against an
// arithmetic reference model, plus handshake, reset and back-to-back scenarios on D=4.
module tb_serial_skip_adder;

    localparam int N = 16;
    localparam int NI = 3;
    localparam int DW [NI] = '{4, 1, 16};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         start_i [NI];
    logic         busy_o  [NI];
    logic         done_o  [NI];
    logic [N-1:0] sum_o   [NI];
    logic         cout_o  [NI];
    logic         ovf_o   [NI];

    serial_skip_adder #(.N(N), .D(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy_o[0]), .done(done_o[0]), .sum(sum_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]));
    serial_skip_adder #(.N(N), .D(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy_o[1]), .done(done_o[1]), .sum(sum_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]));
    serial_skip_adder #(.N(N), .D(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .start(start_i[2]), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy_o[2]), .done(done_o[2]), .sum(sum_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2]));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Returns {ovf, cout, sum} from plain integer arithmetic and sign rules.
    function automatic logic [N+1:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                           input logic ci, input logic s);
        int unsigned xu, yu, r;
        logic [N-1:0] res;
        logic co, ov;
        xu = int'(x);
        yu = int'(y);
        if (s) begin
            r   = xu - yu;
            co  = (xu >= yu);
            res = r[N-1:0];
            ov  = (x[N-1] != y[N-1]) && (res[N-1] != x[N-1]);
        end else begin
            r   = xu + yu + int'(ci);
            co  = (r >= (1 << N));
            res = r[N-1:0];
            ov  = (x[N-1] == y[N-1]) && (res[N-1] != x[N-1]);
        end
        return {ov, co, res};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation on all instances, scrambles inputs after accept, checks all three.
    task automatic run_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic ci, input logic s);
        logic [N+1:0] exp;
        logic [N+1:0] got [NI];
        int lat [NI];
        int busy_bad;
        int done_cnt;
        exp = model(x, y, ci, s);
        a = x; b = y; cin = ci; sub = s;
        for (int k = 0; k < NI; k++) begin
            start_i[k] = 1'b1;
            lat[k] = -1;
            got[k] = 'x;
        end
        tick();
        for (int k = 0; k < NI; k++) start_i[k] = 1'b0;
        a = N'($urandom); b = N'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        busy_bad = busy_o[0] ? 0 : 1;
        done_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            for (int k = 0; k < NI; k++) begin
                if (done_o[k] && lat[k] < 0) begin
                    lat[k] = c;
                    got[k] = {ovf_o[k], cout_o[k], sum_o[k]};
                end
            end
            if (done_o[0]) done_cnt++;
            if ((c < 4) != busy_o[0]) busy_bad++;
            if (busy_o[0] && done_o[0]) busy_bad++;
        end
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s/D%0d latency", tag, DW[k]), lat[k], N / DW[k]);
            check($sformatf("%s/D%0d sum", tag, DW[k]), got[k][N-1:0], exp[N-1:0]);
            check($sformatf("%s/D%0d cout", tag, DW[k]), got[k][N], exp[N]);
            check($sformatf("%s/D%0d ovf", tag, DW[k]), got[k][N+1], exp[N+1]);
        end
        check($sformatf("%s busy window", tag), busy_bad, 0);
        check($sformatf("%s done pulses", tag), done_cnt, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_done, second_done, done_cnt;
        logic [N-1:0] first_sum, second_sum;
        logic [N-1:0] ra, rb;
        logic rs, rc;

        for (int k = 0; k < NI; k++) start_i[k] = 1'b0;

        #2;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("reset D%0d outputs", DW[k]),
                  {busy_o[k], done_o[k], sum_o[k], cout_o[k], ovf_o[k]}, 0);
        end
        #10 rst_n = 1'b1;

        run_op("basic_add", 16'h1234, 16'h4321, 1'b0, 1'b0);
        run_op("skip_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        run_op("skip_b1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1);
        run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1);
        run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1);

        // start pulsed during RUN must not disturb the running operation
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        first_done = -1; first_sum = 'x; done_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) begin
                a = 16'h0F0F; b = 16'h0F0F; start_i[0] = 1'b1;
            end else if (c == 2) begin
                start_i[0] = 1'b0;
            end
            if (done_o[0]) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = c;
                    first_sum = sum_o[0];
                end
            end
        end
        check("run_start latency", first_done, 4);
        check("run_start sum", first_sum, 16'h3333);
        check("run_start done pulses", done_cnt, 1);

        // asynchronous reset in the middle of RUN
        a = 16'h1234; b = 16'h0001; cin = 1'b0; sub = 1'b0; start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        tick();
        check("pre_reset busy", busy_o[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check("async reset outputs", {busy_o[0], done_o[0], sum_o[0], cout_o[0], ovf_o[0]}, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("post_reset idle", {busy_o[0], done_o[0]}, 0);
        run_op("post_reset_add", 16'h0001, 16'h0001, 1'b0, 1'b0);

        // start held through DONE: next accept in the DONE cycle, results 5 cycles apart
        a = 16'h0101; b = 16'h0202; cin = 1'b0; sub = 1'b0; start_i[0] = 1'b1;
        tick();
        first_done = -1; second_done = -1; first_sum = 'x; second_sum = 'x; done_cnt = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (done_o[0]) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = c;
                    first_sum = sum_o[0];
                end else if (second_done < 0) begin
                    second_done = c;
                    second_sum = sum_o[0];
                end
            end
            if (c == 4) begin
                a = 16'h1000; b = 16'h0001;
            end
            if (c == 6) start_i[0] = 1'b0;
        end
        check("b2b first latency", first_done, 4);
        check("b2b first sum", first_sum, 16'h0303);
        check("b2b second latency", second_done, 9);
        check("b2b second sum", second_sum, 16'h1001);
        check("b2b done pulses", done_cnt, 2);
        repeat (20) tick();

        for (int i = 0; i < 8; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            run_op($sformatf("rand%0d", i), ra, rb, rc, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_skip_adder.md
# serial_skip_adder

Parametrised digit-serial adder/subtractor. It processes D bits per clock through a registered carry-skip digit stage and produces an N-bit sum, carry-out and signed overflow after N/D cycles. It sits beside the combinational skip adders and is used where area matters more than latency. It has a start/busy/done handshake so a controller can sequence multi-cycle arithmetic.

## Interface
Parameters:
- N, 16, operand width; N must be a multiple of D
- D, 4, digit width in bits processed per cycle; 1 ≤ D ≤ N

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  N  operand A, latched on accepted start
- b  input  N  operand B, latched on accepted start
- cin  input  1  carry-in for add, latched on accepted start
- sub  input  1  1 = compute a − b, 0 = a + b + cin; latched on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result becomes valid
- sum  output  N  result, held until the next result
- cout  output  1  carry out of bit N−1 (for sub: 1 = no borrow)
- ovf  output  1  two's-complement overflow

## Operation
- **States:** IDLE, RUN, DONE.
  - IDLE → RUN on start.
  - RUN → DONE after N/D digit steps.
  - DONE → RUN if start is high, else → IDLE.
  - start in RUN is ignored.
- **Accept:**
  - Load shift register A ← a.
  - Load shift register B ← (sub ? ~b : b).
  - Load carry register ← (sub ? 1 : cin); cin is ignored when sub=1.
  - Load digit counter ← N/D−1.
- **Each RUN cycle:**
  - Add the low D bits of A and B with the carry register.
  - Inside the digit: propagate P = a_d ^ b_d. Digit carry-out = (&P) ? carry_in : ripple carry-out (skip path). The result must equal the D-bit ripple sum.
  - Shift the D sum bits into the top of the sum shift register.
  - Shift A and B right by D.
  - Update the carry register and decrement the counter.
- **Last digit (counter = 0):**
  - Capture the carry into bit N−1 (internal ripple carry into the digit MSB) for overflow.
  - Update outputs: sum ← completed shift register; cout ← final carry; ovf ← carry into MSB ^ carry out of MSB.
  - Outputs change only at this edge.
- **Arithmetic:** sum = (a + b + cin) mod 2^N, or (a − b) mod 2^N. There is no width growth; cout carries the extra bit.
- **Reset (async, any state including mid-RUN):**
  - State → IDLE.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - All shift registers, counter and carry cleared.
  - The partial result is discarded.
- **Release:** reset deassertion is synchronous to clk; the first start is accepted at the first rising edge after release.

## Timing
- Start is accepted at edge E0. busy=1 from E0 until EN/D.
- Digits are computed at edges E1…EN/D.
- At EN/D: sum, cout and ovf are updated, done=1, busy=0. done stays high for exactly one cycle.
- **Latency:** N/D cycles from the accept edge to done. For N=16, D=4 that is 4 cycles.
- **Throughput:**
  - With start high in the DONE cycle: the new operation is accepted at EN/D+1 and busy re-asserts. One result every N/D+1 cycles.
  - Otherwise the block returns to IDLE.
- a, b, cin and sub may change freely after the accept edge.
- done and busy are never high together.

## Test plan
All scenarios use N=16, D=4 unless stated.
1. **Basic add:** a=0x1234, b=0x4321, cin=0, sub=0 → done exactly 4 cycles after accept; sum=0x5555, cout=0, ovf=0; busy high for the 4 cycles before done.
2. **Skip path:**
   - a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0.
   - a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0.
3. **Subtract:**
   - a=0x0005, b=0x0007, sub=1, cin=1 → sum=0xFFFE, cout=0, ovf=0 (cin ignored).
   - a=0x0007, b=0x0005 → sum=0x0002, cout=1.
4. **Overflow:**
   - a=0x7FFF, b=0x0001 add → sum=0x8000, cout=0, ovf=1.
   - a=0x8000, b=0x0001 sub → sum=0x7FFF, cout=1, ovf=1.
5. **Control:**
   - start pulsed during RUN → ignored, result unchanged.
   - Sequence: rst_n low for 1 cycle mid-RUN → outputs 0 immediately (async), state IDLE. A subsequent add of 0x0001+0x0001 → sum=0x0002.
   - start held high through DONE → back-to-back results every 5 cycles.
6. **Parameter sweep:** D=1 (16 cycles) and D=16 (1 cycle), random operands → results match the reference model a+b+cin / a−b, with correct cout and ovf.
